// File: rtl/multdiv_issue.sv
// multdiv_issue: issue/collect stage in front of the multiply and divide units.
// Latches the request, holds operands stable for the selected unit, releases
// that unit's counter reset, stalls upstream until the unit answers (or the
// busy timer expires), then presents the payload to writeback on valid/ack.
// Optional build macro: DIV_ZERO_SHORTCUT_EN (divide by zero answered in IDLE
// without running the divider).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for ctrl_mult/ctrl_div, both units held in reset
// S_START | one cycle, selected unit still in reset, busy counter cleared
// S_BUSY  | selected unit running, waiting for its resultRDY or timeout
// S_DONE  | payload valid to writeback, waiting for wb_ack

module multdiv_issue #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int TAG_W          = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [31:0]      in_opA,
    input  logic [31:0]      in_opB,
    input  logic [TAG_W-1:0] in_rd,
    output logic             stall,
    output logic [31:0]      md_opA,
    output logic [31:0]      md_opB,
    output logic             mult_rst,
    output logic             div_rst,
    input  logic [31:0]      mult_result,
    input  logic             mult_exception,
    input  logic             mult_resultRDY,
    input  logic [31:0]      div_result,
    input  logic             div_exception,
    input  logic             div_resultRDY,
    output logic             wb_valid,
    output logic [31:0]      wb_result,
    output logic             wb_exception,
    output logic [TAG_W-1:0] wb_rd,
    output logic             wb_is_div,
    input  logic             wb_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_op_div;
    logic [31:0]        r_md_opA;
    logic [31:0]        r_md_opB;
    logic [TAG_W-1:0]   r_rd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wb_valid;
    logic [31:0]        r_wb_result;
    logic               r_wb_exception;
    logic [TAG_W-1:0]   r_wb_rd;
    logic               r_wb_is_div;

    logic               w_req;
    logic               w_div_zero;
    logic               w_sel_rdy;
    logic [31:0]        w_sel_result;
    logic               w_sel_exception;
    logic               w_timeout;
    logic               w_busy;

    assign w_req = ctrl_div | ctrl_mult;

`ifdef DIV_ZERO_SHORTCUT_EN
    assign w_div_zero = ctrl_div && (in_opB == 32'd0);
`else
    assign w_div_zero = 1'b0;
`endif

    assign w_sel_rdy       = r_op_div ? div_resultRDY : mult_resultRDY;
    assign w_sel_result    = r_op_div ? div_result    : mult_result;
    assign w_sel_exception = r_op_div ? div_exception : mult_exception;
    assign w_timeout       = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_busy          = (r_state == S_BUSY);

    // A unit only leaves reset while it is the one being waited on in BUSY;
    // reset_n forces both into reset immediately, not one edge later.
    assign mult_rst = !reset_n || !(w_busy && !r_op_div);
    assign div_rst  = !reset_n || !(w_busy &&  r_op_div);

    assign stall        = (r_state != S_IDLE);
    assign md_opA       = r_md_opA;
    assign md_opB       = r_md_opB;
    assign wb_valid     = r_wb_valid;
    assign wb_result    = r_wb_result;
    assign wb_exception = r_wb_exception;
    assign wb_rd        = r_wb_rd;
    assign wb_is_div    = r_wb_is_div;

    // Issue/collect sequencer: request latch, busy timer and writeback payload.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_op_div       <= 1'b0;
            r_md_opA       <= '0;
            r_md_opB       <= '0;
            r_rd           <= '0;
            r_cnt          <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_result    <= '0;
            r_wb_exception <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_is_div    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_md_opA <= in_opA;
                        r_md_opB <= in_opB;
                        r_rd     <= in_rd;
                        r_op_div <= ctrl_div;
                        if (w_div_zero) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_result    <= '0;
                            r_wb_exception <= 1'b1;
                            r_wb_rd        <= in_rd;
                            r_wb_is_div    <= 1'b1;
                            r_state        <= S_DONE;
                        end else begin
                            r_state <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Ready wins over a timeout landing on the same cycle.
                    if (w_sel_rdy) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_result    <= w_sel_result;
                        r_wb_exception <= w_sel_exception;
                        r_wb_rd        <= r_rd;
                        r_wb_is_div    <= r_op_div;
                        r_state        <= S_DONE;
                    end else if (w_timeout) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_result    <= '0;
                        r_wb_exception <= 1'b1;
                        r_wb_rd        <= r_rd;
                        r_wb_is_div    <= r_op_div;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (wb_ack) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
